xc_malu_pmul_seq: RTL and testbench

XC_MALU_PMUL_SEQ -- requirements
Module: xc_malu_pmul_seq

---
 rtl/xc_malu_pmul_seq.sv | 177 +++++++++++++++++
 tb/tb_xc_malu_pmul_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_pmul_seq.sv
// Sequential packed-multiply controller: steps an external shift-add datapath
// one multiplier bit per cycle. Optional pw legality check: XC_MALU_PMUL_SEQ_PWCHECK_EN.

module xc_malu_pmul_seq_chk (
   input  logic       g_clk,
   input  logic       g_reset,
   input  logic [1:0] state,
   input  logic [5:0] counter,
   input  logic       ready,
   input  logic       busy
);

   // Counter runaway would mean finished never arrived
   a_cnt_63: assert property (@(posedge g_clk) disable iff (g_reset) counter != 6'd63);
   a_cnt_16: assert property (@(posedge g_clk) disable iff (g_reset) counter <= 6'd16);
   a_state:  assert property (@(posedge g_clk) disable iff (g_reset) state != 2'd3);
   a_rdy:    assert property (@(posedge g_clk) disable iff (g_reset) ready |-> busy);

endmodule

module xc_malu_pmul_seq (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        flush,
   input  logic        valid,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [4:0]  pw,
   input  logic        high,
   output logic        ready,
   output logic [31:0] result,
   output logic        busy,
   output logic        error,
   output logic [5:0]  counter,
   output logic [63:0] accumulator,
   output logic [31:0] argument,
   input  logic [63:0] n_accumulator,
   input  logic [32:0] n_argument,
   input  logic        finished,
   input  logic [31:0] pmul_result_hi,
   input  logic [31:0] pmul_result_lo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

`ifdef XC_MALU_PMUL_SEQ_PWCHECK_EN
   function automatic logic pw_legal(input logic [4:0] p);
      logic [3:0] w;
      w = p[4:1];
      pw_legal = (p[0] == 1'b0) && (w != 4'd0) && ((w & (w - 4'd1)) == 4'd0);
   endfunction
`endif

   logic [1:0]  state_r;
   logic [1:0]  state_nx_s;
   logic [4:0]  pw_r;
   logic        high_r;
   logic        ready_r;
   logic        busy_r;
   logic        error_r;
   logic [31:0] result_r;
   logic [5:0]  counter_r;
   logic [63:0] acc_r;
   logic [31:0] arg_r;
   logic        fin_s;
   logic        accept_s;
   logic        bad_pw_s;
   logic        unused_s;

   // finished is forced at 16 so an unchecked illegal pw cannot hang the block
   assign fin_s    = finished | (counter_r == 6'd16);
   assign accept_s = (state_r == ST_IDLE) && valid && !flush;

`ifdef XC_MALU_PMUL_SEQ_PWCHECK_EN
   assign bad_pw_s = !pw_legal(pw);
`else
   assign bad_pw_s = 1'b0;
`endif

   // rs1 feeds the datapath directly; top bit of n_argument is a shift-out
   assign unused_s = ^{rs1, n_argument[32], pw_r};

   // Next-state selection; flush overrides every other transition
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (valid) begin
               if (bad_pw_s) state_nx_s = ST_DONE;
               else          state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (fin_s) state_nx_s = ST_DONE;
            else       state_nx_s = ST_RUN;
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
      if (flush) state_nx_s = ST_IDLE;
      else       state_nx_s = state_nx_s;
   end

   // State, status outputs and latched operation controls
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         pw_r    <= 5'd0;
         high_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         ready_r <= (state_nx_s == ST_DONE);
         busy_r  <= (state_nx_s != ST_IDLE);
         if (accept_s) begin
            pw_r   <= pw;
            high_r <= high;
         end
      end
   end

   // Result and error change only on entry to DONE
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         result_r <= 32'd0;
         error_r  <= 1'b0;
      end else if (!flush) begin
         if ((state_r == ST_RUN) && fin_s) begin
            result_r <= high_r ? pmul_result_hi : pmul_result_lo;
            error_r  <= 1'b0;
         end else if (accept_s && bad_pw_s) begin
            result_r <= 32'd0;
            error_r  <= 1'b1;
         end
      end
   end

   // Step registers: load on acceptance, advance while running
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         counter_r <= 6'd0;
         acc_r     <= 64'd0;
         arg_r     <= 32'd0;
      end else if (accept_s) begin
         counter_r <= 6'd0;
         acc_r     <= 64'd0;
         arg_r     <= rs2;
      end else if ((state_r == ST_RUN) && !fin_s && !flush) begin
         counter_r <= counter_r + 6'd1;
         acc_r     <= n_accumulator;
         arg_r     <= n_argument[31:0];
      end
   end

   assign ready       = ready_r;
   assign busy        = busy_r;
   assign error       = error_r;
   assign result      = result_r;
   assign counter     = counter_r;
   assign accumulator = acc_r;
   assign argument    = arg_r;

   xc_malu_pmul_seq_chk u_chk (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .state   (state_r),
      .counter (counter_r),
      .ready   (ready_r),
      .busy    (busy_r)
   );

endmodule

// File: tb/tb_xc_malu_pmul_seq.sv
// Bench for xc_malu_pmul_seq: behavioural shift-add step datapath plus a
// scoreboard of expected results from a direct lane-multiply reference.

module tb_xc_malu_pmul_seq;

   logic        g_clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        flush = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] rs1 = 32'd0;
   logic [31:0] rs2 = 32'd0;
   logic [4:0]  pw = 5'b00010;
   logic        high = 1'b0;
   logic        ready;
   logic [31:0] result;
   logic        busy;
   logic        error;
   logic [5:0]  counter;
   logic [63:0] accumulator;
   logic [31:0] argument;
   logic [63:0] n_accumulator;
   logic [32:0] n_argument;
   logic        finished;
   logic [31:0] pmul_result_hi;
   logic [31:0] pmul_result_lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic        err;
      bit          chk_res;
      int          lat;
   } exp_t;
   exp_t sb[$];

   xc_malu_pmul_seq dut (
      .g_clk          (g_clk),
      .g_reset        (g_reset),
      .flush          (flush),
      .valid          (valid),
      .rs1            (rs1),
      .rs2            (rs2),
      .pw             (pw),
      .high           (high),
      .ready          (ready),
      .result         (result),
      .busy           (busy),
      .error          (error),
      .counter        (counter),
      .accumulator    (accumulator),
      .argument       (argument),
      .n_accumulator  (n_accumulator),
      .n_argument     (n_argument),
      .finished       (finished),
      .pmul_result_hi (pmul_result_hi),
      .pmul_result_lo (pmul_result_lo)
   );

   always #5 g_clk = ~g_clk;

   function automatic int lane_w(input logic [4:0] p);
      case (p)
         5'b00010: return 16;
         5'b00100: return 8;
         5'b01000: return 4;
         5'b10000: return 2;
         default:  return 0;
      endcase
   endfunction

   // One shift-add step: add rs1 lane << cnt into each lane product whose multiplier bit is set
   function automatic logic [63:0] dp_step(input logic [63:0] acc, input logic [31:0] arg,
                                           input logic [31:0] a, input int w, input int cnt);
      logic [63:0] r, m2, m1, la, pr;
      r = acc;
      if (w == 0) return acc;
      m2 = (64'd1 << (2 * w)) - 64'd1;
      m1 = (64'd1 << w) - 64'd1;
      for (int i = 0; i < 32 / w; i++) begin
         if (arg[i * w]) begin
            la = (64'(a) >> (i * w)) & m1;
            pr = (acc >> (2 * w * i)) & m2;
            pr = (pr + (la << cnt)) & m2;
            r  = (r & ~(m2 << (2 * w * i))) | (pr << (2 * w * i));
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] dp_half(input logic [63:0] acc, input int w, input bit hi);
      logic [63:0] m1, v;
      logic [31:0] r;
      r = 32'd0;
      if (w == 0) return r;
      m1 = (64'd1 << w) - 64'd1;
      for (int i = 0; i < 32 / w; i++) begin
         v = (acc >> (2 * w * i + (hi ? w : 0))) & m1;
         r = r | 32'(v << (w * i));
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_pmul(input logic [31:0] a, input logic [31:0] b,
                                            input int w, input logic h);
      longint unsigned m, la, lb, p;
      logic [31:0] r;
      r = 32'd0;
      m = (64'd1 << w) - 64'd1;
      for (int i = 0; i < 32 / w; i++) begin
         la = (64'(a) >> (i * w)) & m;
         lb = (64'(b) >> (i * w)) & m;
         p  = la * lb;
         p  = h ? ((p >> w) & m) : (p & m);
         r  = r | 32'(p << (i * w));
      end
      return r;
   endfunction

   always_comb begin
      n_accumulator  = dp_step(accumulator, argument, rs1, lane_w(pw), int'(counter));
      n_argument     = {1'b0, argument} >> 1;
      finished       = (lane_w(pw) != 0) && (int'(counter) == lane_w(pw));
      pmul_result_lo = dp_half(accumulator, lane_w(pw), 1'b0);
      pmul_result_hi = dp_half(accumulator, lane_w(pw), 1'b1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [4:0] p, input logic h,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic err, input bit chk_res, input int lat);
      exp_t e;
      int got_lat;
      sb.push_back('{tag, res, err, chk_res, lat});
      @(posedge g_clk); #1;
      pw = p; high = h; rs1 = a; rs2 = b; valid = 1'b1;
      got_lat = -1;
      for (int n = 0; n < 40 && got_lat < 0; n++) begin
         @(negedge g_clk);
         if (n == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
         if (ready) begin
            got_lat = n;
            valid = 1'b0;
         end
      end
      valid = 1'b0;
      e = sb.pop_front();
      chk({e.tag, "_lat"}, 64'(got_lat), 64'(e.lat));
      chk({e.tag, "_err"}, 64'(error), 64'(e.err));
      if (e.chk_res) chk({e.tag, "_res"}, 64'(result), 64'(e.res));
      @(negedge g_clk);
      chk({e.tag, "_pulse"}, 64'(ready), 64'd0);
      chk({e.tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [31:0] a, b, prev;
      logic [4:0]  p;
      logic        h;
      bit          saw;

      // Reset state
      repeat (2) @(posedge g_clk);
      #1;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_counter", 64'(counter), 64'd0);
      g_reset = 1'b0;

      // Directed vectors
      run_op("v16", 5'b00010, 1'b0, 32'h0003_0003, 32'h0005_0005, 32'h000F_000F, 1'b0, 1'b1, 18);
      run_op("v8h", 5'b00100, 1'b1, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FE, 1'b0, 1'b1, 10);
      run_op("v2", 5'b10000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b1, 4);

      // Result holds while idle
      prev = 32'h5555_5555;
      repeat (3) @(negedge g_clk);
      chk("hold_res", 64'(result), 64'(prev));

      // Random legal operations against the lane-multiply reference
      for (int k = 0; k < 6; k++) begin
         a = $urandom; b = $urandom;
         p = 5'b00010 << $urandom_range(0, 3);
         h = 1'($urandom_range(0, 1));
         run_op("rnd", p, h, a, b, ref_pmul(a, b, lane_w(p), h), 1'b0, 1'b1, lane_w(p) + 2);
      end

      // Flush in cycle 5 of a 16-bit operation, new request in cycle 7
      @(posedge g_clk); #1;
      pw = 5'b00010; high = 1'b0; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; valid = 1'b1;
      saw = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge g_clk);
         if (ready) saw = 1'b1;
         @(posedge g_clk); #1;
         if (c == 4) begin flush = 1'b1; valid = 1'b0; end
         if (c == 5) flush = 1'b0;
      end
      @(negedge g_clk);
      if (ready) saw = 1'b1;
      chk("flush_noready", 64'(saw), 64'd0);
      chk("flush_idle", 64'(busy), 64'd0);
      run_op("post_flush", 5'b00010, 1'b1, 32'h0007_FFFF, 32'h0009_FFFF,
             ref_pmul(32'h0007_FFFF, 32'h0009_FFFF, 16, 1'b1), 1'b0, 1'b1, 18);

      // Asynchronous reset mid-RUN
      @(posedge g_clk); #1;
      pw = 5'b00100; high = 1'b0; rs1 = 32'h0102_0304; rs2 = 32'h0506_0708; valid = 1'b1;
      repeat (4) @(posedge g_clk);
      #3;
      g_reset = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(ready), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_result", 64'(result), 64'd0);
      chk("mid_rst_counter", 64'(counter), 64'd0);
      chk("mid_rst_acc", accumulator, 64'd0);
      chk("mid_rst_arg", 64'(argument), 64'd0);
      valid = 1'b0;
      @(posedge g_clk); #1;
      g_reset = 1'b0;
      run_op("post_rst", 5'b01000, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D,
             ref_pmul(32'hDEAD_BEEF, 32'hCAFE_F00D, 4, 1'b1), 1'b0, 1'b1, 6);

      // Illegal pack width
`ifdef XC_MALU_PMUL_SEQ_PWCHECK_EN
      run_op("bad_pw", 5'b00001, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b1, 1'b1, 1);
`else
      run_op("bad_pw", 5'b00001, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0, 1'b0, 18);
`endif
      run_op("after_bad", 5'b00100, 1'b0, 32'h0000_0A0B, 32'h0000_0C0D,
             ref_pmul(32'h0000_0A0B, 32'h0000_0C0D, 8, 1'b0), 1'b0, 1'b1, 10);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
